// File: rtl/mdio_poll_arbiter_if.sv
// Request/response channel shared by the CPU register port and the MDIOCtrl port.
// The master drives requests and accepts responses; the slave does the reverse.
interface mdio_poll_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_fiad;
    logic [4:0]  req_rgad;
    logic [15:0] req_data;
    logic        req_isWR;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;

    modport master (
        output req_valid, req_fiad, req_rgad, req_data, req_isWR, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_fiad, req_rgad, req_data, req_isWR, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mdio_poll_arbiter.sv
// Shares the MDIOCtrl channel between the CPU port and a periodic BMSR poller; tracks link state.
// Optional MDIO_POLL_IRQ_EN adds a sticky link-change interrupt (irq_o / irq_clr_i).
module mdio_poll_arbiter #(
    parameter int       POLL_PERIOD = 1000000,
    parameter bit [4:0] PHY_ADDR    = 5'd1,
    parameter bit [4:0] STAT_REG    = 5'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef MDIO_POLL_IRQ_EN
    output logic                 irq_o,
    input  logic                 irq_clr_i,
`endif
    input  logic                 poll_en_i,
    mdio_poll_arbiter_if.slave   cpu,
    mdio_poll_arbiter_if.master  mdio,
    output logic                 link_up_o,
    output logic                 link_chg_o,
    output logic [15:0]          stat_reg_o
);
    localparam int TW = $clog2(POLL_PERIOD);

    typedef enum logic [2:0] {
        IDLE, CPU_REQ, CPU_WAIT, CPU_RESP, POLL_REQ, POLL_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_q, pend_d;
    logic          last_poll_q, last_poll_d;
    logic [4:0]    fiad_q, fiad_d, rgad_q, rgad_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          iswr_q, iswr_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [15:0]   stat_q, stat_d;
    logic          link_q, link_d;
    logic          chg_q, chg_d;
    logic          wrap, poll_win, poll_take;

    assign wrap     = poll_en_i && (timer_q == TW'(POLL_PERIOD - 1));
    assign poll_win = pend_q && (!last_poll_q || !cpu.req_valid);

    always_comb begin
        state_d         = state_q;
        last_poll_d     = last_poll_q;
        fiad_d          = fiad_q;
        rgad_d          = rgad_q;
        wdata_d         = wdata_q;
        iswr_d          = iswr_q;
        rdata_d         = rdata_q;
        stat_d          = stat_q;
        link_d          = link_q;
        chg_d           = 1'b0;
        poll_take       = 1'b0;
        cpu.req_ready   = 1'b0;
        cpu.resp_valid  = 1'b0;
        mdio.req_valid  = 1'b0;
        mdio.resp_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (poll_win) begin
                    poll_take   = 1'b1;
                    last_poll_d = 1'b1;
                    fiad_d      = PHY_ADDR;
                    rgad_d      = STAT_REG;
                    wdata_d     = 16'h0000;
                    iswr_d      = 1'b0;
                    state_d     = POLL_REQ;
                end else begin
                    // Ready is gated by reset so every handshake output reads 0 while held.
                    cpu.req_ready = !rst_i;
                    if (cpu.req_valid) begin
                        last_poll_d = 1'b0;
                        fiad_d      = cpu.req_fiad;
                        rgad_d      = cpu.req_rgad;
                        wdata_d     = cpu.req_data;
                        iswr_d      = cpu.req_isWR;
                        state_d     = CPU_REQ;
                    end
                end
            end
            CPU_REQ, POLL_REQ: begin
                mdio.req_valid = 1'b1;
                if (mdio.req_ready) state_d = (state_q == CPU_REQ) ? CPU_WAIT : POLL_WAIT;
            end
            CPU_WAIT: begin
                mdio.resp_ready = 1'b1;
                if (mdio.resp_valid) begin
                    rdata_d = mdio.resp_data;
                    state_d = CPU_RESP;
                end
            end
            CPU_RESP: begin
                cpu.resp_valid = 1'b1;
                if (cpu.resp_ready) state_d = IDLE;
            end
            POLL_WAIT: begin
                mdio.resp_ready = 1'b1;
                if (mdio.resp_valid) begin
                    stat_d  = mdio.resp_data;
                    link_d  = mdio.resp_data[2];
                    chg_d   = mdio.resp_data[2] != link_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh expiry in the same cycle as a poll start re-arms the pending flag.
    always_comb begin
        timer_d = poll_en_i ? (wrap ? '0 : timer_q + TW'(1)) : '0;
        if (!poll_en_i)     pend_d = 1'b0;
        else if (wrap)      pend_d = 1'b1;
        else if (poll_take) pend_d = 1'b0;
        else                pend_d = pend_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            last_poll_q <= 1'b0;
            fiad_q      <= '0;
            rgad_q      <= '0;
            wdata_q     <= '0;
            iswr_q      <= 1'b0;
            rdata_q     <= '0;
            stat_q      <= '0;
            link_q      <= 1'b0;
            chg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            last_poll_q <= last_poll_d;
            fiad_q      <= fiad_d;
            rgad_q      <= rgad_d;
            wdata_q     <= wdata_d;
            iswr_q      <= iswr_d;
            rdata_q     <= rdata_d;
            stat_q      <= stat_d;
            link_q      <= link_d;
            chg_q       <= chg_d;
        end
    end

`ifdef MDIO_POLL_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          irq_q <= 1'b0;
        else if (chg_q)     irq_q <= 1'b1;
        else if (irq_clr_i) irq_q <= 1'b0;
    end
    assign irq_o = irq_q;
`endif

    assign mdio.req_fiad = fiad_q;
    assign mdio.req_rgad = rgad_q;
    assign mdio.req_data = wdata_q;
    assign mdio.req_isWR = iswr_q;
    assign cpu.resp_data = rdata_q;
    assign link_up_o     = link_q;
    assign link_chg_o    = chg_q;
    assign stat_reg_o    = stat_q;
endmodule
